// File: rtl/mmio_pkg.sv
// Shared constants and FSM state types for the picorv32 AXI4-lite MMIO splitter.
package mmio_pkg;

  localparam logic [31:0] RAM_BYTES_DEF    = 32'd131072;
  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h1000_0000;
  localparam logic [31:0] PASS_ADDR_DEF    = 32'h2000_0000;
  localparam logic [31:0] PASS_MAGIC_DEF   = 32'd123456789;
  localparam int          FIFO_DEPTH_DEF   = 16;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_LOCAL, W_RESP} wr_state_t;
  typedef enum logic [2:0] {R_IDLE, R_FWD, R_WAIT, R_LOCAL, R_RESP} rd_state_t;

  function automatic logic in_ram(input logic [31:0] addr, input logic [31:0] ram_bytes);
    return addr < ram_bytes;
  endfunction

endpackage

// File: rtl/mmio_byte_fifo.sv
// Console byte buffer: power-of-two depth, head visible on dout while not empty.
module mmio_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  // full is sampled before any same-cycle pop, so a pop never admits a push
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi4lite_mmio_splitter.sv
// Splits picorv32 AXI4-lite traffic: RAM window forwarded, console/pass MMIO terminated locally.
// state   | meaning
// W_IDLE  | collect AW and W independently, decode once both latched
// W_FWD   | replay AW/W downstream, wait for downstream B
// W_LOCAL | perform console/pass/oob side effect
// W_RESP  | hold s_bvalid until accepted
// R_IDLE  | accept AR and decode
// R_FWD   | present AR downstream
// R_WAIT  | wait for downstream R
// R_LOCAL | out-of-range read returns zero
// R_RESP  | hold s_rvalid/s_rdata until accepted
module axi4lite_mmio_splitter
  import mmio_pkg::*;
#(
  parameter logic [31:0] RAM_BYTES    = RAM_BYTES_DEF,
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
  parameter logic [31:0] PASS_ADDR    = PASS_ADDR_DEF,
  parameter logic [31:0] PASS_MAGIC   = PASS_MAGIC_DEF,
  parameter int          FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  input  logic [2:0]  s_arprot,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  output logic        con_valid,
  input  logic        con_ready,
  output logic [7:0]  con_data,
  output logic        tests_passed,
  output logic        oob_error
);
  wr_state_t   wr_state;
  rd_state_t   rd_state;
  logic        aw_latched, w_latched;
  logic [31:0] awaddr_q, wdata_q, araddr_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  arprot_q;
  logic        oob_wr, oob_rd;
  logic        con_push, con_pop, con_full, con_empty;

  assign m_awaddr  = awaddr_q;
  assign m_awprot  = 3'b000;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_araddr  = araddr_q;
  assign m_arprot  = arprot_q;
  assign oob_error = oob_wr | oob_rd;
  assign con_valid = !con_empty;
  assign con_pop   = con_valid && con_ready;
  assign con_push  = (wr_state == W_LOCAL) && (awaddr_q == CONSOLE_ADDR) && !con_full;

  mmio_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_con_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (con_push),
    .din   (wdata_q[7:0]),
    .full  (con_full),
    .pop   (con_pop),
    .dout  (con_data),
    .empty (con_empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state     <= W_IDLE;
      aw_latched   <= 1'b0;
      w_latched    <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      s_awready    <= 1'b0;
      s_wready     <= 1'b0;
      s_bvalid     <= 1'b0;
      m_awvalid    <= 1'b0;
      m_wvalid     <= 1'b0;
      m_bready     <= 1'b0;
      tests_passed <= 1'b0;
      oob_wr       <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (s_awvalid && s_awready) begin
            aw_latched <= 1'b1;
            awaddr_q   <= s_awaddr;
            s_awready  <= 1'b0;
          end else if (!aw_latched) s_awready <= 1'b1;
          if (s_wvalid && s_wready) begin
            w_latched <= 1'b1;
            wdata_q   <= s_wdata;
            wstrb_q   <= s_wstrb;
            s_wready  <= 1'b0;
          end else if (!w_latched) s_wready <= 1'b1;
          if (aw_latched && w_latched) begin
            if (in_ram(awaddr_q, RAM_BYTES)) begin
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              wr_state  <= W_FWD;
            end else wr_state <= W_LOCAL;
          end
        end
        W_FWD: begin
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready)  m_wvalid  <= 1'b0;
          if (m_bready && m_bvalid) begin
            m_bready <= 1'b0;
            s_bvalid <= 1'b1;
            wr_state <= W_RESP;
          end else if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) m_bready <= 1'b1;
        end
        W_LOCAL: begin
          if (awaddr_q == CONSOLE_ADDR) begin
            if (!con_full) begin
              s_bvalid <= 1'b1;
              wr_state <= W_RESP;
            end
          end else begin
            if (awaddr_q == PASS_ADDR) begin
              if (wdata_q == PASS_MAGIC) tests_passed <= 1'b1;
            end else oob_wr <= 1'b1;
            s_bvalid <= 1'b1;
            wr_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_bready) begin
            s_bvalid   <= 1'b0;
            aw_latched <= 1'b0;
            w_latched  <= 1'b0;
            s_awready  <= 1'b1;
            s_wready   <= 1'b1;
            wr_state   <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state  <= R_IDLE;
      araddr_q  <= '0;
      arprot_q  <= '0;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      oob_rd    <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (s_arvalid && s_arready) begin
            araddr_q  <= s_araddr;
            arprot_q  <= s_arprot;
            s_arready <= 1'b0;
            if (in_ram(s_araddr, RAM_BYTES)) begin
              m_arvalid <= 1'b1;
              rd_state  <= R_FWD;
            end else begin
              oob_rd   <= 1'b1;
              rd_state <= R_LOCAL;
            end
          end else s_arready <= 1'b1;
        end
        R_FWD: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            rd_state  <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (m_rvalid) begin
            s_rdata  <= m_rdata;
            m_rready <= 1'b0;
            s_rvalid <= 1'b1;
            rd_state <= R_RESP;
          end
        end
        R_LOCAL: begin
          s_rdata  <= '0;
          s_rvalid <= 1'b1;
          rd_state <= R_RESP;
        end
        R_RESP: begin
          if (s_rready) begin
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
            rd_state  <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_mmio_splitter.sv
// Self-checking bench: random-latency RAM slave, queue/array reference model of MMIO effects.
`timescale 1ns/1ps
module tb_axi4lite_mmio_splitter;
  localparam logic [31:0] RAM_B  = 32'd131072;
  localparam logic [31:0] CON_A  = 32'h1000_0000;
  localparam logic [31:0] PASS_A = 32'h2000_0000;
  localparam logic [31:0] MAGIC  = 32'd123456789;
  localparam int          TMO    = 200;

  logic        clk, resetn;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic [2:0]  s_arprot;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        con_valid, con_ready, tests_passed, oob_error;
  logic [7:0]  con_data;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] ref_mem [int];
  logic [7:0]  exp_con [$];
  logic        exp_passed = 1'b0;
  logic        exp_oob = 1'b0;
  int          con_seen = 0;

  // downstream slave state
  logic [31:0] slave_mem [int];
  bit          hold_b = 0, hold_r = 0;
  bit          aw_pend = 0, w_pend = 0, ar_pend = 0, b_fire = 0, r_fire = 0;
  int          ds_wr_cnt = 0, ds_rd_cnt = 0;
  logic [31:0] ds_awaddr, ds_wdata, ds_araddr;
  logic [3:0]  ds_wstrb;
  logic [2:0]  ds_awprot, ds_arprot;

  axi4lite_mmio_splitter dut (
    .clk(clk), .resetn(resetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .con_valid(con_valid), .con_ready(con_ready), .con_data(con_data),
    .tests_passed(tests_passed), .oob_error(oob_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (a >= RAM_B) return 32'h0;
    if (ref_mem.exists(int'(a[31:2]))) return ref_mem[int'(a[31:2])];
    return 32'h0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a < RAM_B) ref_mem[int'(a[31:2])] = merge(ref_read(a), d, s);
    else if (a == CON_A) exp_con.push_back(d[7:0]);
    else if (a == PASS_A) begin if (d == MAGIC) exp_passed = 1'b1; end
    else exp_oob = 1'b1;
  endfunction

  // downstream write slave: random readies, optional B hold
  initial begin
    m_awready = 0; m_wready = 0; m_bvalid = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; aw_pend = 0; w_pend = 0; b_fire = 0;
      end else begin
        if (b_fire) begin m_bvalid = 0; b_fire = 0; end
        if (aw_pend && w_pend && !m_bvalid && !hold_b && $urandom_range(0, 1) == 1) begin
          slave_mem[int'(ds_awaddr[31:2])] = merge(slave_mem.exists(int'(ds_awaddr[31:2])) ?
                                           slave_mem[int'(ds_awaddr[31:2])] : 32'h0, ds_wdata, ds_wstrb);
          m_bvalid = 1; aw_pend = 0; w_pend = 0;
        end
        m_awready = !aw_pend && ($urandom_range(0, 2) != 0);
        if (m_awvalid && m_awready) begin
          aw_pend = 1; ds_awaddr = m_awaddr; ds_awprot = m_awprot; ds_wr_cnt++;
        end
        m_wready = !w_pend && ($urandom_range(0, 2) != 0);
        if (m_wvalid && m_wready) begin w_pend = 1; ds_wdata = m_wdata; ds_wstrb = m_wstrb; end
        b_fire = m_bvalid && m_bready;
      end
    end
  end

  // downstream read slave
  initial begin
    m_arready = 0; m_rvalid = 0; m_rdata = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_arready = 0; m_rvalid = 0; ar_pend = 0; r_fire = 0;
      end else begin
        if (r_fire) begin m_rvalid = 0; r_fire = 0; end
        if (ar_pend && !m_rvalid && !hold_r && $urandom_range(0, 1) == 1) begin
          m_rdata = slave_mem.exists(int'(ds_araddr[31:2])) ? slave_mem[int'(ds_araddr[31:2])] : 32'h0;
          m_rvalid = 1; ar_pend = 0;
        end
        m_arready = !ar_pend && !m_rvalid && ($urandom_range(0, 2) != 0);
        if (m_arvalid && m_arready) begin
          ar_pend = 1; ds_araddr = m_araddr; ds_arprot = m_arprot; ds_rd_cnt++;
        end
        r_fire = m_rvalid && m_rready;
      end
    end
  end

  // console stream monitor
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk); #1;
      if (resetn && con_valid && con_ready) begin
        checks++; con_seen++;
        if (exp_con.size() == 0) begin
          errors++; $display("FAIL con_extra: got byte %h, expected none", con_data);
        end else begin
          e = exp_con.pop_front();
          if (con_data !== e) begin errors++; $display("FAIL con_order: got %h expected %h", con_data, e); end
        end
      end
    end
  end

  task automatic send_aw(input logic [31:0] a);
    int n;
    n = 0; s_awaddr = a; s_awvalid = 1;
    while (!s_awready && n < TMO) begin @(negedge clk); n++; end
    if (!s_awready) begin checks++; errors++; $display("FAIL aw_timeout: awready 0 after %0d cycles, expected 1", n); end
    @(negedge clk); s_awvalid = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0; s_wdata = d; s_wstrb = s; s_wvalid = 1;
    while (!s_wready && n < TMO) begin @(negedge clk); n++; end
    if (!s_wready) begin checks++; errors++; $display("FAIL w_timeout: wready 0 after %0d cycles, expected 1", n); end
    @(negedge clk); s_wvalid = 0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [2:0] p);
    int n;
    n = 0; s_araddr = a; s_arprot = p; s_arvalid = 1;
    while (!s_arready && n < TMO) begin @(negedge clk); n++; end
    if (!s_arready) begin checks++; errors++; $display("FAIL ar_timeout: arready 0 after %0d cycles, expected 1", n); end
    @(negedge clk); s_arvalid = 0;
  endtask

  task automatic wr_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int mode);
    case (mode)
      0: begin send_aw(a); send_w(d, s); end
      1: begin send_w(d, s); send_aw(a); end
      default: fork send_aw(a); send_w(d, s); join
    endcase
  endtask

  task automatic wr_resp();
    int n;
    n = 0; s_bready = 1;
    while (!s_bvalid && n < TMO) begin @(negedge clk); n++; end
    if (!s_bvalid) begin checks++; errors++; $display("FAIL b_timeout: bvalid 0 after %0d cycles, expected 1", n); end
    @(negedge clk); s_bready = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int mode);
    model_write(a, d, s);
    wr_issue(a, d, s, mode);
    wr_resp();
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] p, output logic [31:0] d);
    int n;
    logic [31:0] d0;
    bit stable;
    send_ar(a, p);
    n = 0; s_rready = 0;
    while (!s_rvalid && n < TMO) begin @(negedge clk); n++; end
    if (!s_rvalid) begin checks++; errors++; $display("FAIL r_timeout: rvalid 0 after %0d cycles, expected 1", n); end
    d0 = s_rdata; stable = 1;
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      if (!s_rvalid || s_rdata !== d0) stable = 0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL rdata_hold: rvalid/rdata got %b/%h expected 1/%h", s_rvalid, s_rdata, d0); end
    s_rready = 1; @(negedge clk); s_rready = 0;
    d = d0;
  endtask

  task automatic rd_check(input logic [31:0] a);
    logic [31:0] got, exp;
    logic [2:0]  p;
    int          c0;
    p = 3'($urandom_range(0, 7)); c0 = ds_rd_cnt; exp = ref_read(a);
    rd(a, p, got);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL rd_data @%h: got %h expected %h", a, got, exp); end
    if (a < RAM_B) begin
      checks++;
      if (ds_rd_cnt != c0 + 1 || ds_araddr !== a || ds_arprot !== p) begin
        errors++; $display("FAIL rd_fwd @%h: got cnt %0d addr %h prot %0d expected cnt %0d addr %h prot %0d",
                           a, ds_rd_cnt - c0, ds_araddr, ds_arprot, 1, a, p);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 0;
    s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0; con_ready = 0;
    s_awaddr = 0; s_wdata = 0; s_wstrb = 0; s_araddr = 0; s_arprot = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, m_awvalid, m_wvalid, m_bready,
         m_arvalid, m_rready, con_valid, tests_passed, oob_error} !== 13'b0 || s_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_state: outputs not all zero (rdata %h)", s_rdata);
    end
    resetn = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      errors++; $display("FAIL idle_ready: got aw/w/ar ready %b expected 111", {s_awready, s_wready, s_arready});
    end
  endtask

  task automatic test_ram_write();
    int n, c0;
    bit early;
    c0 = ds_wr_cnt; hold_b = 1;
    model_write(32'h100, 32'hDEADBEEF, 4'b0011);
    wr_issue(32'h100, 32'hDEADBEEF, 4'b0011, 0);
    n = 0;
    while (!(aw_pend && w_pend) && n < TMO) begin @(negedge clk); n++; end
    checks++;
    if (ds_wr_cnt != c0 + 1 || ds_awaddr !== 32'h100 || ds_wdata !== 32'hDEADBEEF ||
        ds_wstrb !== 4'b0011 || ds_awprot !== 3'b000) begin
      errors++; $display("FAIL ram_fwd: got cnt %0d addr %h data %h strb %b prot %0d expected 1 100 deadbeef 0011 0",
                         ds_wr_cnt - c0, ds_awaddr, ds_wdata, ds_wstrb, ds_awprot);
    end
    early = 0;
    repeat (4) begin @(negedge clk); if (s_bvalid) early = 1; end
    checks++;
    if (early) begin errors++; $display("FAIL bvalid_early: got bvalid 1 before downstream B, expected 0"); end
    hold_b = 0;
    wr_resp();
    rd_check(32'h100);
  endtask

  task automatic test_console_timing();
    con_ready = 1;
    model_write(CON_A, 32'h41, 4'b0001);
    send_w(32'h41, 4'b0001);
    send_aw(CON_A);
    checks++;
    if (s_bvalid !== 1'b0) begin errors++; $display("FAIL con_b_t0: got bvalid %b expected 0", s_bvalid); end
    @(negedge clk);
    checks++;
    if (s_bvalid !== 1'b0) begin errors++; $display("FAIL con_b_t1: got bvalid %b expected 0", s_bvalid); end
    @(negedge clk);
    checks++;
    if (s_bvalid !== 1'b1 || con_valid !== 1'b1 || con_data !== 8'h41) begin
      errors++; $display("FAIL con_b_t2: got bvalid %b con_valid %b data %h expected 1 1 41", s_bvalid, con_valid, con_data);
    end
    @(negedge clk);
    checks++;
    if (con_valid !== 1'b0) begin errors++; $display("FAIL con_one_cycle: got con_valid %b expected 0", con_valid); end
    wr_resp();
  endtask

  task automatic test_fifo_full();
    logic [7:0] b;
    bit early;
    int seen0, n;
    con_ready = 0; seen0 = con_seen;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      wr(CON_A, {24'($urandom), b}, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
    end
    b = 8'($urandom);
    model_write(CON_A, {24'h0, b}, 4'b0000);
    wr_issue(CON_A, {24'h0, b}, 4'b0000, $urandom_range(0, 2));
    early = 0;
    repeat (6) begin @(negedge clk); if (s_bvalid) early = 1; end
    checks++;
    if (early) begin errors++; $display("FAIL fifo_full_stall: got bvalid 1 while full, expected 0"); end
    checks++;
    if (con_valid !== 1'b1 || con_data !== exp_con[0]) begin
      errors++; $display("FAIL fifo_head: got valid %b data %h expected 1 %h", con_valid, con_data, exp_con[0]);
    end
    con_ready = 1; @(negedge clk); con_ready = 0;
    wr_resp();
    con_ready = 1; n = 0;
    while (exp_con.size() != 0 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (exp_con.size() != 0 || con_seen - seen0 != 17 || con_valid !== 1'b0) begin
      errors++; $display("FAIL fifo_drain: got %0d bytes left %0d seen valid %b expected 0 17 0",
                         exp_con.size(), con_seen - seen0, con_valid);
    end
  endtask

  task automatic test_pass();
    logic [31:0] vals [3];
    vals[0] = 32'd123456788; vals[1] = 32'd123456789; vals[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      wr(PASS_A, vals[i], 4'hF, $urandom_range(0, 2));
      checks++;
      if (tests_passed !== exp_passed || oob_error !== exp_oob) begin
        errors++; $display("FAIL pass_reg[%0d]: got passed %b oob %b expected %b %b", i, tests_passed, oob_error, exp_passed, exp_oob);
      end
    end
  endtask

  task automatic test_oob_concurrent();
    int c0;
    logic [31:0] got;
    wr(32'h0001_FFFC, $urandom, 4'hF, $urandom_range(0, 2));
    rd_check(32'h0001_FFFC);
    checks++;
    if (oob_error !== 1'b0) begin errors++; $display("FAIL oob_ram_top: got oob %b expected 0", oob_error); end
    c0 = ds_wr_cnt;
    wr(RAM_B, $urandom, 4'hF, $urandom_range(0, 2));
    checks++;
    if (oob_error !== exp_oob || ds_wr_cnt != c0) begin
      errors++; $display("FAIL oob_write: got oob %b fwd %0d expected %b 0", oob_error, ds_wr_cnt - c0, exp_oob);
    end
    c0 = ds_rd_cnt;
    rd(32'h3000_0000, 3'b000, got);
    checks++;
    if (got !== 32'h0 || oob_error !== 1'b1 || ds_rd_cnt != c0) begin
      errors++; $display("FAIL oob_read: got data %h oob %b fwd %0d expected 0 1 0", got, oob_error, ds_rd_cnt - c0);
    end
    fork
      wr(32'h200, $urandom, 4'($urandom_range(1, 15)), 2);
      rd_check(32'h100);
    join
    rd_check(32'h200);
  endtask

  task automatic test_reset_midflight();
    int n, w0, r0, nw, nr;
    logic [31:0] a;
    con_ready = 0;
    wr(CON_A, 32'h55, 4'b0001, 0);
    hold_b = 1; hold_r = 1;
    fork
      wr_issue(32'h300, 32'hCAFEF00D, 4'hF, 2);
      send_ar(32'h100, 3'b001);
    join
    n = 0;
    while (!(m_bready && m_rready) && n < TMO) begin @(negedge clk); n++; end
    checks++;
    if (!(m_bready && m_rready)) begin errors++; $display("FAIL midflight_reach: got bready %b rready %b expected 1 1", m_bready, m_rready); end
    resetn = 0;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
    @(negedge clk);
    checks++;
    if ({s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, con_valid,
         tests_passed, oob_error, s_awready, s_wready, s_arready} !== 13'b0) begin
      errors++; $display("FAIL reset_mid: outputs %b expected all 0",
        {s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, con_valid,
         tests_passed, oob_error, s_awready, s_wready, s_arready});
    end
    exp_con.delete(); exp_passed = 0; exp_oob = 0;
    hold_b = 0; hold_r = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    repeat (2) @(negedge clk);
    rd_check(32'h300);
    w0 = ds_wr_cnt; r0 = ds_rd_cnt; nw = 0; nr = 0;
    for (int i = 0; i < 40; i++) begin
      a = 32'h400 + {26'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 1) == 1) begin
        wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2)); nw++;
      end else begin
        rd_check(a); nr++;
      end
    end
    checks++;
    if (ds_wr_cnt - w0 != nw || ds_rd_cnt - r0 != nr || oob_error !== 1'b0 || tests_passed !== 1'b0) begin
      errors++; $display("FAIL random_traffic: got fwd wr %0d rd %0d oob %b passed %b expected %0d %0d 0 0",
                         ds_wr_cnt - w0, ds_rd_cnt - r0, oob_error, tests_passed, nw, nr);
    end
  endtask

  initial begin
    test_reset();
    test_ram_write();
    test_console_timing();
    test_fifo_full();
    test_pass();
    test_oob_concurrent();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
